// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
//  Module   : player_motion
//  Purpose  : Per-player frame-rate motion engine: clamped horizontal moves,
//             gravity jump FSM and an optional timed kick (PLAYER_KICK_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module player_motion #(
    parameter int W           = 10,
    parameter int SCREEN_W    = 640,
    parameter int PW          = 100,
    parameter int X_INIT      = 10,
    parameter int GROUND_Y    = 200,
    parameter int STEP        = 2,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int FACE_RIGHT  = 1,
    parameter int KICK_FRAMES = 8,
    parameter int KICK_COOL   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         v_sync,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_jump,
    input  logic         btn_kick,
    input  logic [W-1:0] opp_x,
    output logic [W-1:0] xpos,
    output logic [W-1:0] ypos,
    output logic         airborne,
    output logic         kick_active
);

    localparam int XW = W + 2;

    localparam logic signed [XW-1:0] c_STEP   = XW'(STEP);
    localparam logic signed [XW-1:0] c_PW_S   = XW'(PW);
    localparam logic signed [XW-1:0] c_X_MAX  = XW'(SCREEN_W - PW);
    localparam logic [W-1:0]         c_X_INIT = W'(X_INIT);
    localparam logic [W-1:0]         c_GND_Y  = W'(GROUND_Y);
    localparam logic [W:0]           c_GND_Y1 = (W+1)'(GROUND_Y);
    localparam logic [W-1:0]         c_JUMP_V = W'(JUMP_V);
    localparam logic [W:0]           c_JUMP_1 = (W+1)'(JUMP_V);
    localparam logic [W-1:0]         c_GRAV   = W'(GRAVITY);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } jump_state_t;

    logic        r_vs_d;
    logic        w_tick;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_vel;
    jump_state_t r_state;

    assign w_tick = r_vs_d & ~v_sync;

    // ------------------------------------------------------------------------
    // Horizontal motion
    // ------------------------------------------------------------------------
    logic signed [XW-1:0] w_x_cur;
    logic signed [XW-1:0] w_x_cand;
    logic signed [XW-1:0] w_x_wall;
    logic signed [XW-1:0] w_opp_s;
    logic signed [XW-1:0] w_lim;
    logic signed [XW-1:0] w_x_next_s;
    logic [W-1:0]         w_x_next;
    logic [1:0]           w_unused_xhi;

    always_comb begin
        w_x_cur    = signed'({2'b00, r_x});
        w_opp_s    = signed'({2'b00, opp_x});
        w_x_cand   = w_x_cur;
        w_x_wall   = '0;
        w_lim      = '0;
        w_x_next_s = '0;

        case ({btn_left, btn_right})
            2'b10:   w_x_cand = w_x_cur - c_STEP;
            2'b01:   w_x_cand = w_x_cur + c_STEP;
            default: w_x_cand = w_x_cur;
        endcase

        if (w_x_cand < 0)
            w_x_wall = '0;
        else if (w_x_cand > c_X_MAX)
            w_x_wall = c_X_MAX;
        else
            w_x_wall = w_x_cand;

        // Opponent limit: an overlapping box is pushed back out, never deeper in.
        if (FACE_RIGHT != 0) begin
            w_lim = w_opp_s - c_PW_S;
            if (w_lim < 0)
                w_lim = '0;
            w_x_next_s = (w_x_wall > w_lim) ? w_lim : w_x_wall;
        end else begin
            w_lim      = w_opp_s + c_PW_S;
            w_x_next_s = (w_x_wall < w_lim) ? w_lim : w_x_wall;
        end
    end

    assign w_x_next     = w_x_next_s[W-1:0];
    assign w_unused_xhi = w_x_next_s[W+1:W];

    // ------------------------------------------------------------------------
    // Jump FSM
    // ------------------------------------------------------------------------
    jump_state_t  w_state_next;
    logic [W-1:0] w_y_next;
    logic [W-1:0] w_vel_next;
    logic [W:0]   w_vel_inc;
    logic [W-1:0] w_vel_fall;
    logic [W:0]   w_y_sum;

    always_comb begin
        w_state_next = r_state;
        w_y_next     = r_y;
        w_vel_next   = r_vel;
        w_vel_inc    = {1'b0, r_vel} + {1'b0, c_GRAV};
        w_vel_fall   = (w_vel_inc > c_JUMP_1) ? c_JUMP_V : w_vel_inc[W-1:0];
        w_y_sum      = {1'b0, r_y} + {1'b0, w_vel_fall};

        case (r_state)
            ST_GROUND: begin
                if (btn_jump) begin
                    w_state_next = ST_RISE;
                    w_vel_next   = c_JUMP_V;
                end
            end
            ST_RISE: begin
                w_y_next = (r_y >= r_vel) ? (r_y - r_vel) : '0;
                if (r_vel <= c_GRAV) begin
                    w_vel_next   = '0;
                    w_state_next = ST_FALL;
                end else begin
                    w_vel_next = r_vel - c_GRAV;
                end
            end
            ST_FALL: begin
                if (w_y_sum >= c_GND_Y1) begin
                    w_y_next     = c_GND_Y;
                    w_vel_next   = '0;
                    w_state_next = ST_GROUND;
                end else begin
                    w_y_next   = w_y_sum[W-1:0];
                    w_vel_next = w_vel_fall;
                end
            end
            default: begin
                w_state_next = ST_GROUND;
                w_y_next     = c_GND_Y;
                w_vel_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_d  <= 1'b1;
            r_x     <= c_X_INIT;
            r_y     <= c_GND_Y;
            r_vel   <= '0;
            r_state <= ST_GROUND;
        end else begin
            r_vs_d <= v_sync;
            if (w_tick) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_vel   <= w_vel_next;
                r_state <= w_state_next;
            end
        end
    end

    assign xpos     = r_x;
    assign ypos     = r_y;
    assign airborne = (r_state != ST_GROUND);

    // ------------------------------------------------------------------------
    // Kick window
    // ------------------------------------------------------------------------
`ifdef PLAYER_KICK_EN
    localparam int KMAX = (KICK_FRAMES > KICK_COOL) ? KICK_FRAMES : KICK_COOL;
    localparam int KW   = $clog2(KMAX + 1);

    localparam logic [KW-1:0] c_KICK_ACT  = KW'(KICK_FRAMES - 1);
    localparam logic [KW-1:0] c_KICK_WAIT = KW'(KICK_COOL - 1);

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_ACTIVE = 2'd1,
        KS_COOL   = 2'd2
    } kick_state_t;

    kick_state_t   r_kstate;
    kick_state_t   w_kstate_next;
    logic [KW-1:0] r_kcnt;
    logic [KW-1:0] w_kcnt_next;
    logic          r_kick_prev;

    always_comb begin
        w_kstate_next = r_kstate;
        w_kcnt_next   = r_kcnt;
        case (r_kstate)
            KS_IDLE: begin
                if (btn_kick & ~r_kick_prev) begin
                    w_kstate_next = KS_ACTIVE;
                    w_kcnt_next   = c_KICK_ACT;
                end
            end
            KS_ACTIVE: begin
                if (r_kcnt == '0) begin
                    w_kstate_next = KS_COOL;
                    w_kcnt_next   = c_KICK_WAIT;
                end else begin
                    w_kcnt_next = r_kcnt - 1'b1;
                end
            end
            KS_COOL: begin
                if (r_kcnt == '0)
                    w_kstate_next = KS_IDLE;
                else
                    w_kcnt_next = r_kcnt - 1'b1;
            end
            default: begin
                w_kstate_next = KS_IDLE;
                w_kcnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kstate    <= KS_IDLE;
            r_kcnt      <= '0;
            r_kick_prev <= 1'b0;
        end else if (w_tick) begin
            r_kstate    <= w_kstate_next;
            r_kcnt      <= w_kcnt_next;
            r_kick_prev <= btn_kick;
        end
    end

    assign kick_active = (r_kstate == KS_ACTIVE);
`else
    logic w_unused_kick;
    assign w_unused_kick = btn_kick;
    assign kick_active   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_player_motion.sv
`default_nettype none
// ============================================================================
//  Module   : tb_player_motion
//  Purpose  : Scoreboard bench for player_motion: directed frames push their
//             expected outputs, a monitor checks them after each frame tick.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_player_motion;

`ifdef PLAYER_KICK_EN
    localparam bit c_KICK_ON = 1'b1;
`else
    localparam bit c_KICK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v_sync = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_jump = 1'b0;
    logic       btn_kick = 1'b0;
    logic [9:0] opp_x = 10'd600;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       airborne;
    logic       kick_active;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       air;
        logic       kick;
    } exp_t;

    exp_t q[$];

    player_motion dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .v_sync      (v_sync),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_jump    (btn_jump),
        .btn_kick    (btn_kick),
        .opp_x       (opp_x),
        .xpos        (xpos),
        .ypos        (ypos),
        .airborne    (airborne),
        .kick_active (kick_active)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int x, input int y, input logic a, input logic k);
        exp_t e;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.air  = a;
        e.kick = k;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame: buttons applied, expected result queued, v_sync pulsed low.
    task automatic frame(input logic l, input logic r, input logic j, input logic k,
                         input int opp, input int ex, input int ey,
                         input logic ea, input logic ek);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        btn_jump  = j;
        btn_kick  = k;
        opp_x     = 10'(opp);
        q.push_back(mk(ex, ey, ea, ek));
        v_sync    = 1'b0;
        repeat (3) @(negedge clk);
        v_sync = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: the DUT presents a new frame result one clk after v_sync falls.
    initial begin : monitor
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(negedge v_sync);
            @(posedge clk);
            #1;
            checks++;
            n++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL frame%0d: update seen with no expected entry (x=%0d y=%0d)",
                         n, xpos, ypos);
            end else begin
                e = q.pop_front();
                if (xpos !== e.x || ypos !== e.y || airborne !== e.air || kick_active !== e.kick) begin
                    errors++;
                    $display("FAIL frame%0d: got x=%0d y=%0d air=%0b kick=%0b expected x=%0d y=%0d air=%0b kick=%0b",
                             n, xpos, ypos, airborne, kick_active, e.x, e.y, e.air, e.kick);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int x;
        int y;
        logic k;
        logic j;

        repeat (3) @(negedge clk);
        chk("reset_x", int'(xpos), 10);
        chk("reset_y", int'(ypos), 200);
        chk("reset_air", int'(airborne), 0);
        chk("reset_kick", int'(kick_active), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both direction buttons cancel.
        for (int i = 0; i < 3; i++)
            frame(1'b1, 1'b1, 1'b0, 1'b0, 600, 10, 200, 1'b0, 1'b0);

        // Walk right into the opponent limit 600-100 = 500.
        x = 10;
        for (int i = 0; i < 400; i++) begin
            x = (x + 2 > 500) ? 500 : x + 2;
            frame(1'b0, 1'b1, 1'b0, 1'b0, 600, x, 200, 1'b0, 1'b0);
        end

        // Opponent at 101 forces x to 1, then left wall saturates at 0.
        frame(1'b0, 1'b0, 1'b0, 1'b0, 101, 1, 200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            frame(1'b1, 1'b0, 1'b0, 1'b0, 600, 0, 200, 1'b0, 1'b0);

        // Jump while moving right: 12 rise ticks (apex 122), 12 fall ticks.
        x = 2;
        frame(1'b0, 1'b1, 1'b1, 1'b0, 600, x, 200, 1'b1, 1'b0);
        y = 200;
        for (int v = 12; v >= 1; v--) begin
            x += 2;
            y -= v;
            frame(1'b0, 1'b1, 1'b0, 1'b0, 600, x, y, 1'b1, 1'b0);
        end
        for (int v = 1; v <= 11; v++) begin
            x += 2;
            y += v;
            frame(1'b0, 1'b1, 1'b0, 1'b0, 600, x, y, 1'b1, 1'b0);
        end
        x += 2;
        frame(1'b0, 1'b1, 1'b0, 1'b0, 600, x, 200, 1'b0, 1'b0);

        // Kick: 8 active frames, 16 cooldown frames (press at 12 ignored),
        // re-kick at 25 together with a jump.
        for (int i = 0; i <= 25; i++) begin
            k = (i == 0 || i == 12 || i == 25);
            j = (i == 25);
            frame(1'b0, 1'b0, j, k, 600, 50, 200, j,
                  c_KICK_ON && (i <= 7 || i == 25));
        end
        y = 200;
        for (int v = 12; v >= 8; v--) begin
            y -= v;
            frame(1'b0, 1'b0, 1'b0, 1'b0, 600, 50, y, 1'b1, c_KICK_ON);
        end

        // Reset mid-jump/mid-kick with a coincident tick and move request.
        @(negedge clk);
        rst_n     = 1'b0;
        btn_right = 1'b1;
        q.push_back(mk(10, 200, 1'b0, 1'b0));
        v_sync    = 1'b0;
        repeat (3) @(negedge clk);
        v_sync = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Long low v_sync gives exactly one update; rising edge gives none.
        q.push_back(mk(12, 200, 1'b0, 1'b0));
        v_sync = 1'b0;
        repeat (1000) @(negedge clk);
        chk("hold_low_x", int'(xpos), 12);
        v_sync = 1'b1;
        repeat (5) @(negedge clk);
        chk("rise_edge_x", int'(xpos), 12);
        btn_right = 1'b0;

        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_motion.md
# player_motion

Per-player motion engine for the two-player fighting display: converts directional, jump and kick buttons into a frame-rate-updated top-left box position with screen-border clamping, no-pass-through against the opponent, a gravity-driven jump state machine and a timed kick window. One instance per player sits between the switch inputs and the box-drawing logic. Updates happen once per frame, on the falling edge of `v_sync`.

## Interface
Parameters:
- `W`, 10: coordinate width in bits.
- `SCREEN_W`, 640: visible width in pixels.
- `PW`, 100: player box width.
- `X_INIT`, 10: reset x position.
- `GROUND_Y`, 200: y of box top when standing.
- `STEP`, 2: horizontal pixels per frame.
- `JUMP_V`, 12: initial upward velocity, pixels/frame.
- `GRAVITY`, 1: velocity change per frame.
- `FACE_RIGHT`, 1: 1 means the opponent is to the right (player 1); 0 means the opponent is to the left.
- `KICK_FRAMES`, 8: frames `kick_active` is held.
- `KICK_COOL`, 16: frames after a kick during which a new kick is ignored.

Ports:
- `clk`, in, 1: system/pixel clock.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `v_sync`, in, 1: vertical sync from the sync generator.
- `btn_left`, in, 1: move left.
- `btn_right`, in, 1: move right.
- `btn_jump`, in, 1: jump request.
- `btn_kick`, in, 1: kick request.
- `opp_x`, in, W: opponent box x.
- `xpos`, out, W: box x.
- `ypos`, out, W: box y.
- `airborne`, out, 1: high when the FSM is in RISE or FALL.
- `kick_active`, out, 1: kick hitbox enable.

## Operation
- **Frame tick.** `vs_d` registers `v_sync`. The tick is `vs_d & ~v_sync`. All state below changes only on a tick edge.
- **Horizontal candidate.**
  - left only: `x - STEP`.
  - right only: `x + STEP`.
  - both or neither: `x`.
  - Computed in W+2-bit signed arithmetic.
- **Horizontal clamp.** The candidate is clamped to `[0, SCREEN_W-PW]`, then:
  - FACE_RIGHT=1: limited to `opp_x - PW`, floored at 0.
  - FACE_RIGHT=0: floored at `opp_x + PW`.
  - If already overlapping, x never moves further into the opponent.
- **Jump FSM.** States GROUND, RISE, FALL. `vel` is W-bit unsigned.
  - **GROUND.** If `btn_jump` is high at the tick, go to RISE with `vel=JUMP_V`. y is unchanged on this tick.
  - **RISE.** `y -= vel`, saturating at 0. `vel -= GRAVITY`. When the new vel is ≤0, set `vel=0` and go to FALL.
  - **FALL.** `vel += GRAVITY`, capped at `JUMP_V`. When `y + new_vel ≥ GROUND_Y`, set `y=GROUND_Y`, `vel=0` and go to GROUND. Otherwise `y += new_vel`.
  - A jump held through landing re-triggers on the next tick in GROUND.
  - Horizontal motion is allowed in all states.
- **Kick.** Sub-states IDLE, ACTIVE, COOL with frame counter `kcnt`.
  - IDLE: a `btn_kick` rising edge, sampled at ticks (`btn_kick & ~kick_prev`), goes to ACTIVE with `kcnt=KICK_FRAMES-1`.
  - ACTIVE: counts down, then goes to COOL with `kcnt=KICK_COOL-1`.
  - COOL: counts down, then goes to IDLE.
  - `kick_active` is high exactly in ACTIVE.
  - Kick requests in ACTIVE or COOL are discarded.
- **Reset** (`rst_n` low at a clk edge):
  - Outputs: `xpos=X_INIT`, `ypos=GROUND_Y`, `airborne=0`, `kick_active=0`.
  - Internal: FSM GROUND, `vel=0`, kick IDLE, `kcnt=0`, `vs_d=1`, `kick_prev=0`.
  - Reset overrides a coincident tick.
  - Reset mid-jump or mid-kick returns immediately to the reset values.

## Timing
- Update latency: outputs change on the clk edge where `vs_d=1` and `v_sync=0`, i.e. one clk after `v_sync` is first sampled low. They hold for the whole frame.
- All outputs are registered; there are no combinational input-to-output paths.
- Buttons and `opp_x` are sampled only on the tick edge.
- Full jump length with defaults: 12 RISE ticks, then FALL until landing. The apex is `GROUND_Y - 78`.
- Simultaneous events on one tick:
  - jump + move: both applied.
  - kick + jump: both applied.
  - landing + move: landing y and the moved x are both applied.

## Configuration
- `PLAYER_KICK_EN` defined: the kick sub-FSM and counter are built as above.
- `PLAYER_KICK_EN` undefined: no kick logic; `kick_active` is constant 0 and `btn_kick` is ignored.

## Test plan
- **Reset.** Assert `rst_n=0` mid-jump (y=150, RISE) -> next edge: xpos=10, ypos=200, airborne=0, kick_active=0.
- **Right clamp.** FACE_RIGHT=1, opp_x=600, btn_right held 400 frames from x=10 -> x stops at 500 and never exceeds 500.
- **Both buttons and left wall.** btn_left+btn_right held -> x constant. btn_left alone from x=1 with STEP=2 -> x=0 and stays 0.
- **Jump.** btn_jump pulse at one tick -> airborne next tick; y sequence 200, 188, 177, … reaching a minimum of 122; lands at exactly y=200 and airborne=0.
- **Kick** (PLAYER_KICK_EN). Kick press -> kick_active high exactly 8 ticks. Press again during the 16 cooldown ticks -> no kick. Press after cooldown -> kick again.
- **Tick detection.** v_sync held low 1000 clks -> exactly one update. No update on the `v_sync` rising edge.
